// File: rtl/timer_top.sv
`timescale 1ns/1ps
// ============================================================================
// timer_top
// ----------------------------------------------------------------------------
// Memory-mapped 32-bit timer/counter on the dbus. Provides a prescaled
// up-counter with compare match, overflow detection and a level interrupt.
//
// Register map (byte address, bits [1:0] ignored):
//   0x0 CTRL    : [0] EN, [1] RELOAD, [2] IRQ_EN, [3] ONESHOT, [15:8] PRESCALE
//   0x4 COUNT   : read/write
//   0x8 COMPARE : read/write
//   0xC STATUS  : [0] MATCH, [1] OVF, write-1-to-clear
//
// Configuration macro: TIMER_ONESHOT_EN
//   defined   -> CTRL[3] ONESHOT is implemented (stop on compare match)
//   undefined -> CTRL[3] reads 0, writes ignored, no oneshot logic
//
// Ports:
//   clk_bus      in   1   bus/counter clock
//   rst_n        in   1   asynchronous active-low reset
//   bus_address  in   4   byte address
//   bus_data_i   in  32   write data
//   bus_data_o   out 32   read data (combinational, zero-wait)
//   bus_read     in   1   read strobe (reads have no side effects)
//   bus_write    in   1   full-word write strobe
//   irq          out  1   registered level interrupt
// ============================================================================
module timer_top #(
    parameter logic [31:0] RESET_COMPARE  = 32'hFFFF_FFFF,
    parameter logic [7:0]  PRESCALE_RESET = 8'd0
) (
    input  logic        clk_bus,
    input  logic        rst_n,
    input  logic [3:0]  bus_address,
    input  logic [31:0] bus_data_i,
    output logic [31:0] bus_data_o,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic        irq
);

    logic        r_en;
    logic        r_reload;
    logic        r_irq_en;
    logic [7:0]  r_prescale;
    logic [7:0]  r_pcnt;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;
    logic        r_ovf;
    logic        r_irq;
`ifdef TIMER_ONESHOT_EN
    logic        r_oneshot;
    logic        w_os_stop;
`endif

    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_hit;
    logic [32:0] w_inc;
    logic [31:0] w_count_nxt;
    logic [7:0]  w_pcnt_nxt;
    logic        w_set_match;
    logic        w_set_ovf;
    logic        w_match_nxt;
    logic        w_ovf_nxt;
    logic        w_en_nxt;
    logic        w_irq_en_nxt;
    logic        w_oneshot_rd;
    logic        w_unused;

    // The strobe and the byte-lane bits carry no information for this slave.
    assign w_unused = bus_read ^ bus_address[1] ^ bus_address[0];

    // Decode a bus write into one per-register write enable.
    always_comb begin
        w_wr_ctrl    = 1'b0;
        w_wr_count   = 1'b0;
        w_wr_compare = 1'b0;
        w_wr_status  = 1'b0;
        if (bus_write) begin
            case (bus_address[3:2])
                2'd0:    w_wr_ctrl    = 1'b1;
                2'd1:    w_wr_count   = 1'b1;
                2'd2:    w_wr_compare = 1'b1;
                2'd3:    w_wr_status  = 1'b1;
                default: w_wr_ctrl    = 1'b0;
            endcase
        end else begin
            w_wr_ctrl = 1'b0;
        end
    end

    // Prescaler tick, counter next state and hardware status-set events.
    always_comb begin
        w_tick      = r_en && (r_pcnt == r_prescale);
        w_hit       = w_tick && (r_count == r_compare);
        w_inc       = {1'b0, r_count} + 33'd1;
        w_count_nxt = r_count;
        w_set_match = 1'b0;
        w_set_ovf   = 1'b0;
`ifdef TIMER_ONESHOT_EN
        w_os_stop   = 1'b0;
`endif
        if (w_wr_count) begin
            // A bus write discards a coincident tick entirely.
            w_count_nxt = bus_data_i;
        end else if (w_hit) begin
            w_set_match = 1'b1;
`ifdef TIMER_ONESHOT_EN
            if (r_oneshot) begin
                w_os_stop   = 1'b1;
                w_count_nxt = r_count;
            end else if (r_reload) begin
                w_count_nxt = 32'd0;
            end else begin
                // COMPARE == all-ones without reload also reports overflow.
                w_count_nxt = w_inc[31:0];
                w_set_ovf   = w_inc[32];
            end
`else
            if (r_reload) begin
                w_count_nxt = 32'd0;
            end else begin
                // COMPARE == all-ones without reload also reports overflow.
                w_count_nxt = w_inc[31:0];
                w_set_ovf   = w_inc[32];
            end
`endif
        end else if (w_tick) begin
            w_count_nxt = w_inc[31:0];
            w_set_ovf   = w_inc[32];
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Prescaler, enable, status and interrupt-enable next state.
    always_comb begin
        if (w_wr_ctrl || w_wr_count) begin
            w_pcnt_nxt = 8'd0;
        end else if (w_tick) begin
            w_pcnt_nxt = 8'd0;
        end else if (r_en) begin
            w_pcnt_nxt = r_pcnt + 8'd1;
        end else begin
            w_pcnt_nxt = r_pcnt;
        end

        // The written EN value wins over a coincident oneshot stop.
        if (w_wr_ctrl) begin
            w_en_nxt     = bus_data_i[0];
            w_irq_en_nxt = bus_data_i[2];
`ifdef TIMER_ONESHOT_EN
        end else if (w_os_stop) begin
            w_en_nxt     = 1'b0;
            w_irq_en_nxt = r_irq_en;
`endif
        end else begin
            w_en_nxt     = r_en;
            w_irq_en_nxt = r_irq_en;
        end

        // Hardware set is applied after the W1C so a coincident set wins.
        w_match_nxt = (r_match & ~(w_wr_status & bus_data_i[0])) | w_set_match;
        w_ovf_nxt   = (r_ovf   & ~(w_wr_status & bus_data_i[1])) | w_set_ovf;
    end

    // Register state update with asynchronous reset.
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_reload   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= PRESCALE_RESET;
            r_pcnt     <= 8'd0;
            r_count    <= 32'd0;
            r_compare  <= RESET_COMPARE;
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
`ifdef TIMER_ONESHOT_EN
            r_oneshot  <= 1'b0;
`endif
        end else begin
            r_en     <= w_en_nxt;
            r_irq_en <= w_irq_en_nxt;
            if (w_wr_ctrl) begin
                r_reload   <= bus_data_i[1];
                r_prescale <= bus_data_i[15:8];
`ifdef TIMER_ONESHOT_EN
                r_oneshot  <= bus_data_i[3];
`endif
            end
            if (w_wr_compare) begin
                r_compare <= bus_data_i;
            end
            r_pcnt  <= w_pcnt_nxt;
            r_count <= w_count_nxt;
            r_match <= w_match_nxt;
            r_ovf   <= w_ovf_nxt;
            r_irq   <= w_irq_en_nxt & (w_match_nxt | w_ovf_nxt);
        end
    end

`ifdef TIMER_ONESHOT_EN
    assign w_oneshot_rd = r_oneshot;
`else
    assign w_oneshot_rd = 1'b0;
`endif

    // Zero-wait read mux, driven regardless of bus_read.
    always_comb begin
        case (bus_address[3:2])
            2'd0:    bus_data_o = {16'h0000, r_prescale, 4'h0, w_oneshot_rd,
                                   r_irq_en, r_reload, r_en};
            2'd1:    bus_data_o = r_count;
            2'd2:    bus_data_o = r_compare;
            2'd3:    bus_data_o = {30'd0, r_ovf, r_match};
            default: bus_data_o = 32'd0;
        endcase
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_timer_top.sv
`timescale 1ns/1ps
// Self-checking bench for timer_top: directed scenarios with literal
// expectations plus a randomized phase, all checked against a behavioural
// register-level model of the timer.
module tb_timer_top;

    logic        clk_bus = 1'b0;
    logic        rst_n;
    logic [3:0]  bus_address;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        bus_read;
    logic        bus_write;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk_bus = ~clk_bus;

    timer_top dut (
        .clk_bus     (clk_bus),
        .rst_n       (rst_n),
        .bus_address (bus_address),
        .bus_data_i  (bus_data_i),
        .bus_data_o  (bus_data_o),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .irq         (irq)
    );

    // ---------------- behavioural model ----------------
    bit          m_en, m_reload, m_irqen, m_oneshot;
    bit [7:0]    m_pre;
    int unsigned m_pcnt;
    bit [31:0]   m_count, m_cmp;
    bit          m_match, m_ovf, m_irq;

    task automatic model_reset();
        m_en = 0; m_reload = 0; m_irqen = 0; m_oneshot = 0; m_pre = 8'd0;
        m_pcnt = 0; m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
        m_match = 0; m_ovf = 0; m_irq = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {16'h0, m_pre, 4'h0, m_oneshot, m_irqen, m_reload, m_en};
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {30'd0, m_ovf, m_match};
        endcase
    endfunction

    // One clock edge of the timer, driven by the bus inputs present at the edge.
    task automatic model_step();
        bit        tick, hit, set_m, set_o, en_n;
        bit [32:0] inc;
        bit [31:0] cnt_n, d;
        bit [1:0]  sel;
        d     = bus_data_i;
        sel   = bus_address[3:2];
        tick  = m_en && (m_pcnt == m_pre);
        hit   = tick && (m_count == m_cmp);
        set_m = 0; set_o = 0; cnt_n = m_count; en_n = m_en;
        if (tick) begin
            inc = {1'b0, m_count} + 33'd1;
            if (hit && m_oneshot) begin
                set_m = 1; en_n = 0;
            end else if (hit && m_reload) begin
                set_m = 1; cnt_n = 32'd0;
            end else begin
                set_m = hit; cnt_n = inc[31:0]; set_o = inc[32];
            end
        end
        // the prescaler counts modulo PRESCALE+1 while enabled
        if (m_en) m_pcnt = (m_pcnt + 1) % (m_pre + 1);
        if (bus_write) begin
            case (sel)
                2'd0: begin
                    en_n = d[0]; m_reload = d[1]; m_irqen = d[2]; m_pre = d[15:8];
`ifdef TIMER_ONESHOT_EN
                    m_oneshot = d[3];
`endif
                    m_pcnt = 0;
                end
                2'd1: begin cnt_n = d; set_m = 0; set_o = 0; m_pcnt = 0; end
                2'd2: m_cmp = d;
                default: begin
                    if (d[0]) m_match = 0;
                    if (d[1]) m_ovf = 0;
                end
            endcase
        end
        m_match = m_match | set_m;
        m_ovf   = m_ovf | set_o;
        m_count = cnt_n;
        m_en    = en_n;
        m_irq   = m_irqen && (m_match || m_ovf);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, DUT read data and irq against the model.
    always @(negedge clk_bus) begin
        if (chk_en) begin
            check("model_rdata", bus_data_o, m_read(bus_address));
            check("model_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // Drive one bus cycle (called just after a rising edge) and advance the model.
    task automatic step(input bit [3:0] a, input bit w, input bit [31:0] d);
        bus_address = a;
        bus_write   = w;
        bus_data_i  = d;
        bus_read    = 1'($urandom_range(0, 1));
        @(posedge clk_bus);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'h4, 1'b0, 32'd0);
    endtask

    task automatic peek(input string name, input bit [3:0] a, input bit [31:0] exp);
        bus_address = a;
        bus_write   = 1'b0;
        #1;
        check(name, bus_data_o, exp);
    endtask

    // Assert reset mid-cycle with a write pending, then release it.
    task automatic mid_reset();
        bus_address = 4'h4; bus_write = 1'b1; bus_data_i = 32'h0000_0055;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_count", bus_data_o, 32'd0);
        bus_write = 1'b0;
        @(posedge clk_bus);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit [3:0]  a;
        bit        w;
        bit [31:0] d;
        rst_n = 1'b0; bus_address = 4'h0; bus_write = 1'b0; bus_read = 1'b0;
        bus_data_i = 32'd0;
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(posedge clk_bus);
        #1;
        rst_n = 1'b1;

        // reset values
        peek("rst_ctrl", 4'h0, 32'h0000_0000);
        peek("rst_count", 4'h4, 32'h0000_0000);
        peek("rst_compare", 4'h8, 32'hFFFF_FFFF);
        peek("rst_status", 4'hC, 32'h0000_0000);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // periodic match with reload
        step(4'h8, 1'b1, 32'd3);
        step(4'h0, 1'b1, 32'h0000_0007);
        peek("per_c0", 4'h4, 32'd0);
        step(4'h4, 1'b0, 32'd0); peek("per_c1", 4'h4, 32'd1);
        step(4'h4, 1'b0, 32'd0); peek("per_c2", 4'h4, 32'd2);
        step(4'h4, 1'b0, 32'd0); peek("per_c3", 4'h4, 32'd3);
        step(4'h4, 1'b0, 32'd0); peek("per_wrap0", 4'h4, 32'd0);
        peek("per_match", 4'hC, 32'd1);
        check("per_irq_hi", {31'd0, irq}, 32'd1);
        step(4'hC, 1'b1, 32'd1);
        peek("per_clr", 4'hC, 32'd0);
        check("per_irq_lo", {31'd0, irq}, 32'd0);

        // prescale 4: one increment per 5 cycles, CTRL rewrite restarts window
        step(4'h0, 1'b1, 32'd0);
        step(4'h4, 1'b1, 32'd0);
        step(4'h0, 1'b1, 32'h0000_0401);
        idle(4); peek("pre_c0", 4'h4, 32'd0);
        idle(1); peek("pre_c1", 4'h4, 32'd1);
        idle(2);
        step(4'h0, 1'b1, 32'h0000_0401);
        idle(4); peek("pre_restart_hold", 4'h4, 32'd1);
        idle(1); peek("pre_c2", 4'h4, 32'd2);

        // wrap through all-ones
        step(4'h0, 1'b1, 32'd0);
        step(4'hC, 1'b1, 32'd3);
        step(4'h4, 1'b1, 32'hFFFF_FFFE);
        step(4'h8, 1'b1, 32'd5);
        step(4'h0, 1'b1, 32'h0000_0005);
        idle(1); peek("wrap_ff", 4'h4, 32'hFFFF_FFFF);
        idle(1); peek("wrap_0", 4'h4, 32'd0);
        peek("wrap_status", 4'hC, 32'd2);
        check("wrap_irq", {31'd0, irq}, 32'd1);

        // COUNT write colliding with a matching tick
        step(4'h0, 1'b1, 32'd0);
        step(4'hC, 1'b1, 32'd3);
        step(4'h8, 1'b1, 32'h10);
        step(4'h4, 1'b1, 32'h10);
        step(4'h0, 1'b1, 32'h0000_0001);
        step(4'h4, 1'b1, 32'h100);
        peek("col_count", 4'h4, 32'h100);
        peek("col_status", 4'hC, 32'd0);
        // W1C colliding with a new match
        step(4'h8, 1'b1, 32'h101);
        step(4'hC, 1'b1, 32'd1);
        peek("w1c_set_wins", 4'hC, 32'd1);

        // oneshot
        step(4'h0, 1'b1, 32'd0);
        step(4'h4, 1'b1, 32'd0);
        step(4'hC, 1'b1, 32'd3);
        step(4'h8, 1'b1, 32'd2);
        step(4'h0, 1'b1, 32'h0000_000B);
        idle(3);
`ifdef TIMER_ONESHOT_EN
        peek("os_count", 4'h4, 32'd2);
        peek("os_ctrl", 4'h0, 32'h0000_000A);
`else
        peek("os_count", 4'h4, 32'd0);
        peek("os_ctrl", 4'h0, 32'h0000_0003);
`endif
        peek("os_status", 4'hC, 32'd1);

        // asynchronous reset with a pending write
        mid_reset();
        peek("post_rst_compare", 4'h8, 32'hFFFF_FFFF);
        peek("post_rst_count", 4'h4, 32'd0);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            a[3:2] = 2'($urandom_range(0, 3));
            a[1:0] = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 99) < 20);
            d = $urandom;
            case (a[3:2])
                2'd0: begin
                    d[15:8] = 8'($urandom_range(0, 3));
                    d[0]    = ($urandom_range(0, 3) != 0);
                end
                2'd1, 2'd2: begin
                    if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    else d = 32'($urandom_range(0, 40));
                end
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 999) == 0) mid_reset();
            else step(a, w, d);
        end

        @(negedge clk_bus);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
